// File: rtl/regfile_bank_if.sv
// Write/clear port and flat register export for regfile_bank.
// master: the requester side (drives writes and clear pulses).
// slave: the bank itself.
interface regfile_bank_if #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
);
  logic                   wr_valid;
  logic                   wr_ready;
  logic [AW-1:0]          wr_addr;
  logic [WIDTH-1:0]       wr_data;
  logic                   clr_req;
  logic                   busy;
  logic [WIDTH*NREGS-1:0] regs_flat;

  modport master (
    output wr_valid, wr_addr, wr_data, clr_req,
    input  wr_ready, busy, regs_flat
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, clr_req,
    output wr_ready, busy, regs_flat
  );
endinterface

// File: rtl/regfile_bank.sv
// regfile_bank: 32 x WIDTH architectural register bank feeding the 32:1
// BIGMUX read selector. One write per cycle via valid/ready, plus a bulk
// clear that sweeps one entry to zero per cycle.
// Optional build macro REGFILE_ZERO_REG_EN: register 0 reads as constant
// zero; writes to it handshake normally but the data is dropped.
// regs_flat is MSB-first: reg 0 at the top slice, reg NREGS-1 at [WIDTH-1:0].

// One storage entry. Clear has priority, though the top level never
// asserts both in the same cycle (writes are blocked during a sweep).
module regfile_entry #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] q
);
  // entry flop: async clear on reset, sweep clear, or write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= '0;
    else if (clr) q <= '0;
    else if (wr)  q <= wd;
  end
endmodule

module regfile_bank #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  regfile_bank_if.slave  bus
);
  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  state_t                       state;
  logic [AW-1:0]                cnt;
  logic                         busy_q;
  logic                         wr_fire;
  logic                         sweep;
  logic [NREGS-1:0][WIDTH-1:0]  regs;

  // A clear request in IDLE steals the cycle from any concurrent write,
  // so the requester simply sees ready low and retries after the sweep.
  assign bus.wr_ready = (state == IDLE) && !bus.clr_req;
  assign wr_fire      = bus.wr_valid && bus.wr_ready;
  assign sweep        = (state == CLEAR);
  assign bus.busy     = busy_q;

  // control FSM: IDLE accepts writes; CLEAR zeroes entry cnt each cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.clr_req) begin
            state  <= CLEAR;
            cnt    <= '0;
            busy_q <= 1'b1;
          end
        end
        CLEAR: begin
          // clr_req is ignored here; cnt wraps to 0 after LAST
          cnt <= cnt + AW'(1);
          if (cnt == LAST) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // per-entry decode and storage; export straight from the flops
  for (genvar k = 0; k < NREGS; k++) begin : g_ent
    localparam logic [AW-1:0] IDX = AW'(k);
`ifdef REGFILE_ZERO_REG_EN
    if (k == 0) begin : g_zero
      assign regs[k] = '0;
    end else begin : g_rw
      logic hit_wr;
      logic hit_clr;
      assign hit_wr  = wr_fire && (bus.wr_addr == IDX);
      assign hit_clr = sweep && (cnt == IDX);
      regfile_entry #(.WIDTH(WIDTH)) u_ent (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (hit_clr),
        .wr    (hit_wr),
        .wd    (bus.wr_data),
        .q     (regs[k])
      );
    end
`else
    begin : g_rw
      logic hit_wr;
      logic hit_clr;
      assign hit_wr  = wr_fire && (bus.wr_addr == IDX);
      assign hit_clr = sweep && (cnt == IDX);
      regfile_entry #(.WIDTH(WIDTH)) u_ent (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (hit_clr),
        .wr    (hit_wr),
        .wd    (bus.wr_data),
        .q     (regs[k])
      );
    end
`endif
    assign bus.regs_flat[(NREGS-1-k)*WIDTH +: WIDTH] = regs[k];
  end
endmodule

// File: tb/tb_regfile_bank.sv
// Directed bench for regfile_bank: table of single-cycle write vectors,
// then hand-written clear sweep, write/clear collision and reset mid-sweep.
module tb_regfile_bank;
  localparam int WIDTH = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int NV    = 8;

`ifdef REGFILE_ZERO_REG_EN
  localparam logic [31:0] R0_EXP = 32'h0;
`else
  localparam logic [31:0] R0_EXP = 32'hCAFEF00D;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_bank_if #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW)) bus ();

  regfile_bank #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        v;
    logic [4:0]  a;
    logic [31:0] d;
    int          chk;
    logic [31:0] exp;
    logic        rdy;
  } vec_t;

  vec_t        tv [NV];
  logic [31:0] mdl [NREGS];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // BIGMUX-style read: slice k out of the MSB-first flat bus
  function automatic logic [31:0] rd(input int k);
    return bus.regs_flat[(NREGS-1-k)*WIDTH +: WIDTH];
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int busy_cnt;
    int rdy_bad;

    tv[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5,  32'hDEADBEEF, 1'b1};
    tv[1] = '{1'b0, 5'd5,  32'h00000000, 5,  32'hDEADBEEF, 1'b1};
    tv[2] = '{1'b1, 5'd31, 32'hA5A5A5A5, 31, 32'hA5A5A5A5, 1'b1};
    tv[3] = '{1'b1, 5'd9,  32'h11111111, 9,  32'h11111111, 1'b1};
    tv[4] = '{1'b1, 5'd9,  32'h22222222, 9,  32'h22222222, 1'b1};
    tv[5] = '{1'b1, 5'd0,  32'hCAFEF00D, 0,  R0_EXP,       1'b1};
    tv[6] = '{1'b0, 5'd0,  32'h0BADF00D, 5,  32'hDEADBEEF, 1'b1};
    tv[7] = '{1'b1, 5'd1,  32'h00000001, 1,  32'h00000001, 1'b1};
    for (int i = 0; i < NREGS; i++) mdl[i] = 32'h0;

    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.clr_req  = 1'b0;

    // reset and idle
    #12;
    check("reset_flat", {31'b0, |bus.regs_flat}, 32'h0);
    check("reset_busy", {31'b0, bus.busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_flat", {31'b0, |bus.regs_flat}, 32'h0);
    check("idle_busy", {31'b0, bus.busy}, 32'h0);
    check("idle_ready", {31'b0, bus.wr_ready}, 32'h1);

    // table-driven writes
    for (int i = 0; i < NV; i++) begin
      bus.wr_valid = tv[i].v;
      bus.wr_addr  = tv[i].a;
      bus.wr_data  = tv[i].d;
      #1;
      check($sformatf("vec%0d_ready", i), {31'b0, bus.wr_ready}, {31'b0, tv[i].rdy});
      check($sformatf("vec%0d_pre", i), rd(tv[i].chk), mdl[tv[i].chk]);
      @(posedge clk); #1;
      check($sformatf("vec%0d_reg%0d", i, tv[i].chk), rd(tv[i].chk), tv[i].exp);
      mdl[tv[i].chk] = tv[i].exp;
      @(negedge clk);
    end
    bus.wr_valid = 1'b0;

    // clear sweep: fill with ones, then clear
    for (int k = 0; k < NREGS; k++) begin
      @(negedge clk);
      bus.wr_valid = 1'b1;
      bus.wr_addr  = 5'(k);
      bus.wr_data  = 32'hFFFFFFFF;
    end
    @(negedge clk);
    bus.wr_valid = 1'b0;
`ifdef REGFILE_ZERO_REG_EN
    check("fill_r0", rd(0), 32'h0);
    check("fill_r1", rd(1), 32'hFFFFFFFF);
`else
    check("fill_all", {31'b0, &bus.regs_flat}, 32'h1);
`endif
    bus.clr_req = 1'b1;
    #1;
    check("clr_ready_low", {31'b0, bus.wr_ready}, 32'h0);
    @(posedge clk); #1;
    check("clr_busy_set", {31'b0, bus.busy}, 32'h1);
    busy_cnt = 1;
    for (int k = 0; k < NREGS; k++) begin
      @(negedge clk);
      bus.clr_req = (k == 20);  // mid-sweep request must be ignored
      @(posedge clk); #1;
      if (bus.busy) busy_cnt++;
      check($sformatf("sweep_r%0d", k), rd(k), 32'h0);
      if (k == 3)
        check("sweep_r4_pending", rd(4), 32'hFFFFFFFF);
    end
    bus.clr_req = 1'b0;
    check("sweep_busy_cycles", busy_cnt, 32);
    check("sweep_flat_zero", {31'b0, |bus.regs_flat}, 32'h0);
    @(negedge clk);
    check("sweep_ready_back", {31'b0, bus.wr_ready}, 32'h1);

    // write/clear collision: write held through the whole sweep
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 5'd7;
    bus.wr_data  = 32'h12345678;
    bus.clr_req  = 1'b1;
    #1;
    check("coll_ready0", {31'b0, bus.wr_ready}, 32'h0);
    @(posedge clk); #1;
    check("coll_busy", {31'b0, bus.busy}, 32'h1);
    rdy_bad = 0;
    for (int k = 0; k < NREGS; k++) begin
      @(negedge clk);
      bus.clr_req = 1'b0;
      #1;
      if (bus.wr_ready !== 1'b0) rdy_bad++;
      @(posedge clk); #1;
    end
    check("coll_ready_held_low", rdy_bad, 0);
    check("coll_r7_after_sweep", rd(7), 32'h0);
    check("coll_busy_done", {31'b0, bus.busy}, 32'h0);
    @(negedge clk); #1;
    check("coll_ready_idle", {31'b0, bus.wr_ready}, 32'h1);
    @(posedge clk); #1;
    check("coll_r7_written", rd(7), 32'h12345678);
    @(negedge clk);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 5'd20;
    bus.wr_data  = 32'h77777777;
    @(negedge clk);
    bus.wr_valid = 1'b0;
    check("pre_rst_r20", rd(20), 32'h77777777);

    // reset in the middle of a sweep
    bus.clr_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.clr_req = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", {31'b0, bus.busy}, 32'h0);
    check("rst_mid_flat", {31'b0, |bus.regs_flat}, 32'h0);
    check("rst_mid_ready", {31'b0, bus.wr_ready}, 32'h1);
    @(negedge clk);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 5'd31;
    bus.wr_data  = 32'hA5A5A5A5;
    @(posedge clk); #1;
    check("rst_no_commit", rd(31), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_r31", bus.regs_flat[31:0], 32'hA5A5A5A5);
    check("post_rst_r20", rd(20), 32'h0);
    check("post_rst_busy", {31'b0, bus.busy}, 32'h0);
    @(negedge clk);
    bus.wr_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
